// File: rtl/btn_conditioner.sv
// Push-button conditioner: sync, debounce, press/release strobes
// and auto-repeat stepping for the digit counter stage.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HOLD_CYCLES     = 6000000,
    parameter int REPEAT_CYCLES   = 1200000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_N,
    output logic PRESSED,
    output logic PRESS_P,
    output logic RELEASE_P,
    output logic REPEAT_P,
    output logic HELD,
    output logic STEP_P
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_HOLD = 2'd1;
    localparam logic [1:0] REPEAT    = 2'd2;

    localparam logic [23:0] DB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] HLD_LAST = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] REP_LAST = 24'(REPEAT_CYCLES - 1);

    logic        s1;
    logic        s2;
    logic        db;
    logic [23:0] db_cnt;
    logic [23:0] cnt;
    logic [1:0]  state;
    logic        press_p;
    logic        release_p;
    logic        repeat_p;

    logic diff;
    logic hit;
    logic press_acc;
    logic rel_acc;

    assign diff      = (!s2) != db;
    assign hit       = diff && (db_cnt == DB_LAST);
    assign press_acc = hit && !db;
    assign rel_acc   = hit && db;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            db        <= 1'b0;
            db_cnt    <= '0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
        end else begin
            s1        <= BTN_N;
            s2        <= s1;
            press_p   <= press_acc;
            release_p <= rel_acc;
            if (!diff) begin
                db_cnt <= '0;
            end else if (hit) begin
                db     <= ~db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 24'd1;
            end
        end
    end

    // A release accepted on a repeat edge suppresses that repeat.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            cnt      <= '0;
            repeat_p <= 1'b0;
        end else begin
            repeat_p <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_acc) begin
                        state <= WAIT_HOLD;
                        cnt   <= '0;
                    end
                end
                WAIT_HOLD: begin
                    if (rel_acc) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == HLD_LAST) begin
                        state    <= REPEAT;
                        cnt      <= '0;
                        repeat_p <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                REPEAT: begin
                    if (rel_acc) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == REP_LAST) begin
                        cnt      <= '0;
                        repeat_p <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign PRESSED   = db;
    assign PRESS_P   = press_p;
    assign RELEASE_P = release_p;
    assign REPEAT_P  = repeat_p;
    assign HELD      = (state == REPEAT);
    assign STEP_P    = press_p | repeat_p;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed button scenarios checked
// against a sample-history model every cycle plus literal pins.
module tb_btn_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic CLK = 1'b0;
    logic RST_N;
    logic BTN_N;
    logic PRESSED;
    logic PRESS_P;
    logic RELEASE_P;
    logic REPEAT_P;
    logic HELD;
    logic STEP_P;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .BTN_N    (BTN_N),
        .PRESSED  (PRESSED),
        .PRESS_P  (PRESS_P),
        .RELEASE_P(RELEASE_P),
        .REPEAT_P (REPEAT_P),
        .HELD     (HELD),
        .STEP_P   (STEP_P)
    );

    // Model: accept a level once the last DEB synced samples all
    // disagree with it; repeats derive from time since the press.
    bit m_on = 1'b0;
    bit m_s1 = 1'b1;
    bit m_s2 = 1'b1;
    bit m_db = 1'b0;
    bit hist[$];
    int edge_n  = 0;
    int t_press = 0;
    bit e_press = 1'b0;
    bit e_rel   = 1'b0;
    bit e_rep   = 1'b0;
    bit e_held  = 1'b0;

    initial forever begin
        bit p;
        bit flip;
        int d;
        @(posedge CLK);
        if (RST_N !== 1'b1) begin
            m_s1    = 1'b1;
            m_s2    = 1'b1;
            m_db    = 1'b0;
            hist.delete();
            e_press = 1'b0;
            e_rel   = 1'b0;
            e_rep   = 1'b0;
            e_held  = 1'b0;
            m_on    = 1'b1;
        end else begin
            p = !m_s2;
            hist.push_back(p);
            if (hist.size() > DEB) void'(hist.pop_front());
            flip = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] == m_db) flip = 1'b0;
            e_press = flip && !m_db;
            e_rel   = flip && m_db;
            if (flip) begin
                m_db = !m_db;
                if (m_db) t_press = edge_n;
            end
            d = edge_n - t_press;
            e_rep  = m_db && !flip &&
                     (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0));
            e_held = m_db && (d >= HOLD);
            m_s2 = m_s1;
            m_s1 = BTN_N;
        end
        edge_n++;
    end

    initial forever begin
        logic [5:0] got;
        logic [5:0] want;
        @(negedge CLK);
        if (m_on) begin
            got  = {PRESSED, PRESS_P, RELEASE_P, REPEAT_P, HELD, STEP_P};
            want = {m_db, e_press, e_rel, e_rep, e_held, e_press | e_rep};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL model edge=%0d: got %06b want %06b",
                         edge_n, got, want);
            end
        end
    end

    task automatic chk(input string nm, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", nm, got, want);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_pressed"}, PRESSED, 1'b0);
        chk({nm, "_press"}, PRESS_P, 1'b0);
        chk({nm, "_rel"}, RELEASE_P, 1'b0);
        chk({nm, "_rep"}, REPEAT_P, 1'b0);
        chk({nm, "_held"}, HELD, 1'b0);
        chk({nm, "_step"}, STEP_P, 1'b0);
    endtask

    task automatic tick(input logic b, input logic r);
        BTN_N = b;
        RST_N = r;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [10:0] pat;
        BTN_N = 1'b1;
        RST_N = 1'b0;

        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0);
            chk_zero("rst");
        end
        for (int k = 0; k < 6; k++) begin
            tick(1'(k % 2), 1'b0);
            chk("rst_toggle", PRESS_P | RELEASE_P | REPEAT_P, 1'b0);
        end
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b1);

        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b1);
            chk("t2_press", PRESS_P, k == 5);
            chk("t2_pressed", PRESSED, k >= 5);
            chk("t2_rep", REPEAT_P, 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b1);
            chk("t2_rel", RELEASE_P, k == 5);
            chk("t2_pressed_off", PRESSED, k < 5);
        end

        pat = 11'h048;
        for (int k = 0; k < 14; k++) begin
            tick((k <= 10) ? pat[k] : 1'b0, 1'b1);
            chk("t3_press", PRESS_P, k == 12);
            chk("t3_pressed", PRESSED, k >= 12);
        end
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b1);
            chk("t3_rel", RELEASE_P, k == 5);
        end

        for (int k = 0; k < 31; k++) begin
            tick(1'b0, 1'b1);
            chk("t4_press", PRESS_P, k == 5);
            chk("t4_rep", REPEAT_P, k >= 15 && (k - 15) % 3 == 0);
            chk("t4_held", HELD, k >= 15);
            chk("t4_step", STEP_P,
                k == 5 || (k >= 15 && (k - 15) % 3 == 0));
        end

        for (int k = 31; k < 41; k++) begin
            tick(1'b1, 1'b1);
            chk("t5_rep", REPEAT_P, k == 33);
            chk("t5_rel", RELEASE_P, k == 36);
            chk("t5_held", HELD, k < 36);
            chk("t5_pressed", PRESSED, k < 36);
            chk("t5_press", PRESS_P, 1'b0);
        end

        for (int k = 0; k < 17; k++) begin
            tick(1'b0, 1'b1);
            chk("t6_held_pre", HELD, k >= 15);
        end
        tick(1'b0, 1'b0);
        chk_zero("t6_rst");
        for (int j = 0; j < 20; j++) begin
            tick(1'b0, 1'b1);
            chk("t6_press", PRESS_P, j == 5);
            chk("t6_rep", REPEAT_P, j == 15 || j == 18);
            chk("t6_held", HELD, j >= 15);
        end
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
